// File: rtl/sdram_phase_autotune.sv
// Sweeps the ECP5 PLL SDRAM clock phase through one full period, scores each
// position from the memory tester counters, then parks it mid-way through the longest good run.
module sdram_phase_autotune #(
    parameter int PHASE_STEPS   = 32,
    parameter int STEP_PULSE    = 4,
    parameter int SETTLE_CYCLES = 4096,
    parameter int DWELL_CYCLES  = 1000000,
    parameter int MIN_PASSES    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] passcount,
    input  logic [31:0] failcount,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic [7:0]  phase,
    output logic [63:0] good_map,
    output logic [5:0]  best_start,
    output logic [6:0]  best_len,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_SETTLE, S_SNAP, S_DWELL, S_EVAL, S_SCAN, S_DECIDE
    } state_t;

    state_t      state_r, state_next_s;
    logic [31:0] cnt_r, cnt_next_s;
    logic [31:0] p0_r, f0_r;
    logic [7:0]  phase_r;
    logic [5:0]  pos_r, pos_inc_s;
    logic [63:0] good_map_r;
    logic [5:0]  best_start_r;
    logic [6:0]  best_len_r;
    logic        busy_r, done_r, fail_r, phasestep_r;
    logic        moving_r;
    logic [5:0]  remain_r;
    logic [6:0]  scan_i_r, run_r;

    logic        step_fall_s, step_end_s, settle_end_s, dwell_end_s, scan_last_s;
    logic        good_s, scan_bit_s;
    logic [5:0]  scan_idx_s, win_start_s, target_s;
    logic [6:0]  run_next_s;
    logic [7:0]  win_tmp_s, tgt_tmp_s;

    // Timing decodes, position scoring and the scan/centre arithmetic
    always_comb begin
        step_fall_s  = (cnt_r == 32'(STEP_PULSE - 1));
        step_end_s   = (cnt_r == 32'(2 * STEP_PULSE - 1));
        settle_end_s = (cnt_r == 32'(SETTLE_CYCLES - 1));
        dwell_end_s  = (cnt_r == 32'(DWELL_CYCLES - 1));
        scan_last_s  = (scan_i_r == 7'(2 * PHASE_STEPS - 1));
        pos_inc_s    = (pos_r == 6'(PHASE_STEPS - 1)) ? 6'd0 : pos_r + 6'd1;
        // Modular difference tolerates passcount wrap between snapshot and evaluation
        good_s       = (failcount == f0_r) && ((passcount - p0_r) >= 32'(MIN_PASSES));
        if (scan_i_r >= 7'(PHASE_STEPS)) begin
            scan_idx_s = 6'(scan_i_r - 7'(PHASE_STEPS));
        end else begin
            scan_idx_s = scan_i_r[5:0];
        end
        scan_bit_s = good_map_r[scan_idx_s];
        if (!scan_bit_s) begin
            run_next_s = 7'd0;
        end else if (run_r == 7'(PHASE_STEPS)) begin
            run_next_s = run_r;
        end else begin
            run_next_s = run_r + 7'd1;
        end
        win_tmp_s = {1'b0, scan_i_r} + 8'd1 - {1'b0, run_next_s};
        if (win_tmp_s >= 8'(PHASE_STEPS)) begin
            win_start_s = 6'(win_tmp_s - 8'(PHASE_STEPS));
        end else begin
            win_start_s = win_tmp_s[5:0];
        end
        tgt_tmp_s = {2'b00, best_start_r} + {2'b00, best_len_r[6:1]};
        if (best_len_r == 7'(PHASE_STEPS)) begin
            target_s = 6'd0;
        end else if (tgt_tmp_s >= 8'(PHASE_STEPS)) begin
            target_s = 6'(tgt_tmp_s - 8'(PHASE_STEPS));
        end else begin
            target_s = tgt_tmp_s[5:0];
        end
    end

    // Next-state selection; MOVE reuses STEP/SETTLE with moving_r set
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:   if (start) state_next_s = S_STEP; else state_next_s = S_IDLE;
            S_STEP:   if (step_end_s) state_next_s = S_SETTLE; else state_next_s = S_STEP;
            S_SETTLE: begin
                if (!settle_end_s) begin
                    state_next_s = S_SETTLE;
                end else if (!moving_r) begin
                    state_next_s = S_SNAP;
                end else if (remain_r == 6'd0) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_STEP;
                end
            end
            S_SNAP:   state_next_s = S_DWELL;
            S_DWELL:  if (dwell_end_s) state_next_s = S_EVAL; else state_next_s = S_DWELL;
            S_EVAL:   if (pos_r == 6'd0) state_next_s = S_SCAN; else state_next_s = S_STEP;
            S_SCAN:   if (scan_last_s) state_next_s = S_DECIDE; else state_next_s = S_SCAN;
            S_DECIDE: begin
                if (best_len_r == 7'd0 || target_s == 6'd0) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_STEP;
                end
            end
            default:  state_next_s = S_IDLE;
        endcase
        cnt_next_s = (state_next_s != state_r) ? 32'd0 : cnt_r + 32'd1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: step pulse, counter snapshots, bitmap, window search and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= 32'd0;
            p0_r         <= 32'd0;
            f0_r         <= 32'd0;
            phase_r      <= 8'd0;
            pos_r        <= 6'd0;
            good_map_r   <= 64'd0;
            best_start_r <= 6'd0;
            best_len_r   <= 7'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
            phasestep_r  <= 1'b0;
            moving_r     <= 1'b0;
            remain_r     <= 6'd0;
            scan_i_r     <= 7'd0;
            run_r        <= 7'd0;
        end else begin
            cnt_r       <= cnt_next_s;
            phasestep_r <= (state_next_s == S_STEP) && (cnt_next_s < 32'(STEP_PULSE));
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        done_r       <= 1'b0;
                        fail_r       <= 1'b0;
                        good_map_r   <= 64'd0;
                        best_start_r <= 6'd0;
                        best_len_r   <= 7'd0;
                        pos_r        <= 6'd0;
                        busy_r       <= 1'b1;
                        moving_r     <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (step_fall_s) begin
                        phase_r <= phase_r + 8'd1;
                        pos_r   <= pos_inc_s;
                        if (moving_r) begin
                            remain_r <= remain_r - 6'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_end_s && moving_r && remain_r == 6'd0) begin
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        moving_r <= 1'b0;
                    end
                end
                S_SNAP: begin
                    p0_r <= passcount;
                    f0_r <= failcount;
                end
                S_DWELL: begin
                    p0_r <= p0_r;
                end
                S_EVAL: begin
                    good_map_r[pos_r] <= good_s;
                    scan_i_r          <= 7'd0;
                    run_r             <= 7'd0;
                end
                S_SCAN: begin
                    run_r    <= run_next_s;
                    scan_i_r <= scan_i_r + 7'd1;
                    // Strict compare keeps the earliest window on ties
                    if (run_next_s > best_len_r) begin
                        best_len_r   <= run_next_s;
                        best_start_r <= win_start_s;
                    end
                end
                S_DECIDE: begin
                    if (best_len_r == 7'd0) begin
                        fail_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else if (target_s == 6'd0) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        moving_r <= 1'b1;
                        remain_r <= target_s;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign phasedir     = 1'b0;
    assign phaseloadreg = 1'b0;
    assign phasestep    = phasestep_r;
    assign phase        = phase_r;
    assign good_map     = good_map_r;
    assign best_start   = best_start_r;
    assign best_len     = best_len_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign fail         = fail_r;

endmodule

// File: tb/tb_sdram_phase_autotune.sv
// Scoreboard bench: a memory-tester model whose quality depends on the PLL position
// reached by phasestep pulses; expected results come from a brute-force window search.
module tb_sdram_phase_autotune;

    localparam int N  = 8;
    localparam int SP = 2;
    localparam int ST = 4;
    localparam int DW = 20;
    localparam int MP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] passcount = 32'd0;
    logic [31:0] failcount = 32'd0;
    logic        phasedir, phasestep, phaseloadreg, busy, done, fail;
    logic [7:0]  phase;
    logic [63:0] good_map;
    logic [5:0]  best_start;
    logic [6:0]  best_len;

    sdram_phase_autotune #(
        .PHASE_STEPS(N), .STEP_PULSE(SP), .SETTLE_CYCLES(ST),
        .DWELL_CYCLES(DW), .MIN_PASSES(MP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .passcount(passcount), .failcount(failcount),
        .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .phase(phase), .good_map(good_map), .best_start(best_start),
        .best_len(best_len), .busy(busy), .done(done), .fail(fail)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] gm;
        logic [5:0]  bs;
        logic [6:0]  bl;
        logic [7:0]  ph;
        logic        dn;
        logic        fl;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          compared = 0;
    int          mismatched = 0;
    int          exp_phase = 0;
    logic [7:0]  mask = 8'h00;
    bit          stall = 1'b0;
    int          bpos = 0;
    bit          bpos_clear = 1'b0;
    bit          pc_load = 1'b0;
    logic [31:0] pc_val = 32'd0;
    logic        prev_ps = 1'b0;
    logic        prev_busy = 1'b0;
    int          cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Longest circular run of good positions; earliest start wins among equals
    function automatic void ref_window(input logic [7:0] m, output int len_o, output int st_o);
        bit ok;
        len_o = 0;
        st_o  = 0;
        for (int len = N; len >= 1 && len_o == 0; len--) begin
            for (int st = 0; st < N && len_o == 0; st++) begin
                ok = 1'b1;
                for (int k = 0; k < len; k++) if (!m[(st + k) % N]) ok = 1'b0;
                if (ok) begin
                    len_o = len;
                    st_o  = st;
                end
            end
        end
    endfunction

    // Memory tester model: passes every 4 cycles, fails every cycle at a bad PLL position
    initial forever begin
        @(negedge clk);
        cyc++;
        if (pc_load) begin
            passcount = pc_val;
            pc_load   = 1'b0;
        end else if (!stall && (cyc % 4 == 0)) begin
            passcount = passcount + 32'd1;
        end
        if (!mask[bpos]) failcount = failcount + 32'd1;
        if (!rst_n || bpos_clear) begin
            bpos       = 0;
            bpos_clear = 1'b0;
        end else if (prev_ps && !phasestep) begin
            bpos = (bpos + 1) % N;
        end
        prev_ps = phasestep;
    end

    // Monitor: each completed run is compared against the oldest expectation
    initial forever begin
        @(negedge clk);
        if (rst_n && prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_completion: busy fell with no run expected");
            end else begin
                mon_e = exp_q.pop_front();
                check("good_map",   good_map,   mon_e.gm);
                check("best_start", {58'd0, best_start}, {58'd0, mon_e.bs});
                check("best_len",   {57'd0, best_len},   {57'd0, mon_e.bl});
                check("phase",      {56'd0, phase},      {56'd0, mon_e.ph});
                check("done",       {63'd0, done},       {63'd0, mon_e.dn});
                check("fail",       {63'd0, fail},       {63'd0, mon_e.fl});
                check("pll_ctrl",   {62'd0, phasedir, phasestep}, 64'd0);
            end
        end
        prev_busy = busy;
    end

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        bpos_clear = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_case(input logic [7:0] m, input bit stl, input bit poke);
        int   len, st, tgt, t;
        exp_t e;
        mask  = m;
        stall = stl;
        ref_window(stl ? 8'h00 : m, len, st);
        tgt       = (len == 0 || len == N) ? 0 : (st + len / 2) % N;
        exp_phase = (exp_phase + N + tgt) % 256;
        e.gm = {56'd0, (stl ? 8'h00 : m)};
        e.bs = 6'(st);
        e.bl = 7'(len);
        e.ph = 8'(exp_phase);
        e.dn = (len != 0);
        e.fl = (len == 0);
        exp_q.push_back(e);
        pulse_start();
        if (poke) begin
            repeat (30) @(negedge clk);
            #1 start = 1'b1;
            @(negedge clk);
            #1 start = 1'b0;
            check("busy_after_ignored_start", {63'd0, busy}, 64'd1);
        end
        t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL run_timeout: busy still %0b after %0d cycles, expected 0", busy, t);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {phase, good_map[7:0], 1'b0, best_start, best_len, busy, done, fail,
                              phasestep, phasedir, phaseloadreg}, 64'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_case(8'h3C, 1'b0, 1'b0);   // positions 2..5 good: park at 4
        run_case(8'hC3, 1'b0, 1'b0);   // window wraps through 0
        run_case(8'h00, 1'b0, 1'b0);   // nothing good
        run_case(8'hFF, 1'b0, 1'b0);   // whole period good
        run_case(8'h66, 1'b0, 1'b1);   // tie, plus an ignored start mid-run
        run_case(8'hFF, 1'b1, 1'b0);   // tester stalled: no passes
        pc_val  = 32'hFFFF_FFFC;
        pc_load = 1'b1;
        repeat (2) @(negedge clk);
        run_case(8'hFF, 1'b0, 1'b0);   // passcount wraps during early dwells
        for (int r = 0; r < 6; r++) begin
            run_case(8'($urandom_range(0, 255)), 1'b0, (r == 2));
        end

        mask = 8'h3C;
        stall = 1'b0;
        pulse_start();
        repeat (22) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clears", {phase, good_map[7:0], 1'b0, best_start, best_len, busy, done,
                                     fail, phasestep}, 64'd0);
        exp_phase = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_case(8'h3C, 1'b0, 1'b0);   // clean rerun from phase 0

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
